write_queue: RTL

//  Buffers 32-bit result words from the JVM execute stage and drains them one at a time

---
 rtl/write_queue_pkg.sv | 12 +
 rtl/write_queue_fifo_mem.sv | 22 ++
 rtl/write_queue.sv | 124 ++++++++++++
 3 files changed

// File: rtl/write_queue_pkg.sv
// Shared constants for the execute-stage write queue: default geometry and FSM encodings.
package write_queue_pkg;

    localparam int WQ_DEPTH_LOG2 = 3;
    localparam int WQ_DATA_WIDTH = 32;

    localparam logic [1:0] WQ_ST_IDLE  = 2'd0;
    localparam logic [1:0] WQ_ST_ISSUE = 2'd1;
    localparam logic [1:0] WQ_ST_HOLD  = 2'd2;
    localparam logic [1:0] WQ_ST_WAIT  = 2'd3;

endpackage

// File: rtl/write_queue_fifo_mem.sv
// Storage for the write queue: 2^DEPTH_LOG2 x DATA_WIDTH registers, one write port, async read.
module wq_fifo_mem #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/write_queue.sv
// FIFO between the execute stage and the sequential memory writer; one start pulse per word.
// Optional sticky overflow flag when WRITE_QUEUE_OVF_EN is defined.
module write_queue
    import write_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = WQ_DEPTH_LOG2,
    parameter int DATA_WIDTH = WQ_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  idle,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_start,
`ifdef WRITE_QUEUE_OVF_EN
    output logic                  overflow,
`endif
    input  logic                  wr_ready
);

    localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;
    logic                  full_q, empty_q;
    logic [1:0]            state_q,  state_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_start_q, wr_start_d;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  push_ok, pop;

    assign push_ok = push && !full_q;
    // The head leaves storage only once the writer reports it has finished with the word.
    assign pop     = (state_q == WQ_ST_WAIT) && wr_ready;

    wq_fifo_mem #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (push_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_data)
    );

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wr_data_d  = wr_data_q;
        wr_start_d = 1'b0;
        case (state_q)
            WQ_ST_IDLE: begin
                if (!empty_q && wr_ready) begin
                    state_d    = WQ_ST_ISSUE;
                    wr_data_d  = head_data;
                    wr_start_d = 1'b1;
                end
            end
            WQ_ST_ISSUE: state_d = WQ_ST_HOLD;
            // Writer's ready may lag the start pulse by a cycle, so it is not trusted here.
            WQ_ST_HOLD:  state_d = WQ_ST_WAIT;
            WQ_ST_WAIT:  if (wr_ready) state_d = WQ_ST_IDLE;
            default:     state_d = WQ_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            state_q    <= WQ_ST_IDLE;
            wr_data_q  <= '0;
            wr_start_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == DEPTH);
            empty_q    <= (count_d == '0);
            state_q    <= state_d;
            wr_data_q  <= wr_data_d;
            wr_start_q <= wr_start_d;
        end
    end

`ifdef WRITE_QUEUE_OVF_EN
    logic overflow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               overflow_q <= 1'b0;
        else if (push && full_q)  overflow_q <= 1'b1;
    end

    assign overflow = overflow_q;
`endif

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign idle     = empty_q && (state_q == WQ_ST_IDLE);
    assign wr_data  = wr_data_q;
    assign wr_start = wr_start_q;

endmodule
